// File: rtl/flag_sched_pkg.sv
// ----------------------------------------------------------------------------
// flag_sched_pkg
// Shared definitions for the flag crossing scheduler:
//   - flag_state_e : slot FSM states (IDLE, ISSUE, GUARD)
//   - GUARD_DEFAULT: default idle interval after each pulse
//   - rr_next      : round-robin pointer advance with wrap at n
// ----------------------------------------------------------------------------
package flag_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GUARD = 2'd2
    } flag_state_e;

    localparam int unsigned GUARD_DEFAULT = 32'd6;

    // Index following idx in a ring of n entries.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        if (idx + 32'd1 >= n) begin
            return 32'd0;
        end else begin
            return idx + 32'd1;
        end
    endfunction

endpackage

// File: rtl/flag_xdomain_sched_arb.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational N-way round-robin pick. The search starts at ptr and wraps
// from N-1 back to 0; the first set pending bit wins.
// Ports:
//   pending   in  N    request vector
//   ptr       in  IDW  highest-priority index for this pick
//   grant     out N    one-hot grant (all zero when nothing is pending)
//   grantIdx  out IDW  encoded index of the granted bit (0 when none)
// The pointer register itself lives in the parent.
// ----------------------------------------------------------------------------
module rr_arbiter
    import flag_sched_pkg::*;
#(
    parameter int unsigned N   = 32'd4,
    parameter int unsigned IDW = 32'd2
) (
    input  logic [N-1:0]   pending,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grantIdx
);

    logic        found_s;
    int unsigned idx_s;

    // Rotating priority search from ptr, first hit wins.
    always_comb begin
        grant    = {N{1'b0}};
        grantIdx = {IDW{1'b0}};
        found_s  = 1'b0;
        idx_s    = 32'd0;
        for (int unsigned k = 32'd0; k < N; k++) begin
            idx_s = (32'(ptr) + k) % N;
            if (!found_s && pending[idx_s]) begin
                found_s        = 1'b1;
                grant[idx_s]   = 1'b1;
                grantIdx       = IDW'(idx_s);
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/flag_xdomain_sched.sv
// ----------------------------------------------------------------------------
// flag_xdomain_sched
// Shares one toggle-synchroniser flag channel among N source-domain
// requesters. One-cycle requests become sticky pending bits; a round-robin
// pick issues one single-cycle flag_out pulse per slot, followed by a guard
// interval so the destination synchroniser never misses a toggle.
//
// Optional build: define FLAG_SCHED_OVF_CNT_EN to add the CNTW parameter and
// the ovf_count port (saturating count of cycles with at least one drop).
//
// Ports:
//   clk        in  1     source-domain clock
//   rst        in  1     synchronous active-high reset
//   en         in  1     low: no new slot starts, requests still accumulate
//   req        in  N     one-cycle event pulses
//   ovf_clr    in  1     clears overflow flags (and ovf_count)
//   flag_out   out 1     one-cycle pulse to the crossing
//   flag_id    out IDW   index of the last issued requester
//   busy       out 1     high during ISSUE and GUARD
//   pending    out N     sticky pending bits
//   overflow   out N     sticky per-requester drop flags
//   ovf_count  out CNTW  drop-cycle counter (optional build only)
// ----------------------------------------------------------------------------
module flag_xdomain_sched
    import flag_sched_pkg::*;
#(
    parameter int unsigned N     = 32'd4,
    parameter int unsigned IDW   = 32'd2,
    parameter int unsigned GUARD = GUARD_DEFAULT
`ifdef FLAG_SCHED_OVF_CNT_EN
    ,
    parameter int unsigned CNTW  = 32'd8
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [N-1:0]    req,
    input  logic            ovf_clr,
    output logic            flag_out,
    output logic [IDW-1:0]  flag_id,
    output logic            busy,
    output logic [N-1:0]    pending,
    output logic [N-1:0]    overflow
`ifdef FLAG_SCHED_OVF_CNT_EN
    ,
    output logic [CNTW-1:0] ovf_count
`endif
);

    flag_state_e    state_r;
    flag_state_e    state_nxt_s;
    logic [7:0]     cnt_r;
    logic [IDW-1:0] ptr_r;
    logic [N-1:0]   pending_r;
    logic [N-1:0]   overflow_r;
    logic           flag_out_r;
    logic [IDW-1:0] flag_id_r;
    logic           busy_r;

    logic [N-1:0]   grant_s;
    logic [IDW-1:0] grant_idx_s;
    logic           issue_s;
    logic [N-1:0]   clr_s;
    logic [N-1:0]   drop_s;

    rr_arbiter #(
        .N   (N),
        .IDW (IDW)
    ) u_arb (
        .pending  (pending_r),
        .ptr      (ptr_r),
        .grant    (grant_s),
        .grantIdx (grant_idx_s)
    );

    // A slot starts only from IDLE; en is ignored once a slot is running.
    assign issue_s = (state_r == ST_IDLE) && en && (|pending_r);
    assign clr_s   = issue_s ? grant_s : {N{1'b0}};
    // A request that finds its bit set and not being cleared coalesces.
    assign drop_s  = req & pending_r & ~clr_s;

    // Slot sequencing: IDLE -> ISSUE (one cycle) -> GUARD (GUARD cycles).
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (issue_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_nxt_s = ST_GUARD;
            end
            ST_GUARD: begin
                if (cnt_r == 8'd0) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_GUARD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, guard counter and registered pulse/busy/id outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 8'd0;
            flag_out_r <= 1'b0;
            flag_id_r  <= {IDW{1'b0}};
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            flag_out_r <= (state_nxt_s == ST_ISSUE);
            busy_r     <= (state_nxt_s != ST_IDLE);
            if (issue_s) begin
                flag_id_r <= grant_idx_s;
            end else begin
                flag_id_r <= flag_id_r;
            end
            // Loaded while leaving ISSUE so GUARD sees GUARD-1 on its first cycle.
            if (state_r == ST_ISSUE) begin
                cnt_r <= 8'(GUARD - 32'd1);
            end else if ((state_r == ST_GUARD) && (cnt_r != 8'd0)) begin
                cnt_r <= cnt_r - 8'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Round-robin pointer moves just past the granted requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= {IDW{1'b0}};
        end else if (issue_s) begin
            ptr_r <= IDW'(rr_next(32'(grant_idx_s), N));
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Sticky pending bits and overflow flags; a same-cycle drop beats ovf_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r  <= {N{1'b0}};
            overflow_r <= {N{1'b0}};
        end else begin
            pending_r <= (pending_r & ~clr_s) | req;
            if (ovf_clr) begin
                overflow_r <= drop_s;
            end else begin
                overflow_r <= overflow_r | drop_s;
            end
        end
    end

    assign flag_out = flag_out_r;
    assign flag_id  = flag_id_r;
    assign busy     = busy_r;
    assign pending  = pending_r;
    assign overflow = overflow_r;

`ifdef FLAG_SCHED_OVF_CNT_EN
    logic [CNTW-1:0] ovf_cnt_r;

    // Saturating count of cycles containing any drop; simultaneous drops count once.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt_r <= {CNTW{1'b0}};
        end else if (ovf_clr) begin
            ovf_cnt_r <= (|drop_s) ? CNTW'(1'b1) : {CNTW{1'b0}};
        end else if ((|drop_s) && (ovf_cnt_r != {CNTW{1'b1}})) begin
            ovf_cnt_r <= ovf_cnt_r + CNTW'(1'b1);
        end else begin
            ovf_cnt_r <= ovf_cnt_r;
        end
    end

    assign ovf_count = ovf_cnt_r;
`endif

endmodule

// File: tb/tb_flag_xdomain_sched.sv
// ----------------------------------------------------------------------------
// tb_flag_xdomain_sched
// Self-checking bench for flag_xdomain_sched (N=4, GUARD=6). Directed
// scenarios check fixed expected cycles; a randomized run compares every
// output each cycle against a slot-level reference model.
// ----------------------------------------------------------------------------
module tb_flag_xdomain_sched;

    localparam int N     = 4;
    localparam int IDW   = 2;
    localparam int GUARD = 6;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic [N-1:0]   req;
    logic           ovf_clr;
    logic           flag_out;
    logic [IDW-1:0] flag_id;
    logic           busy;
    logic [N-1:0]   pending;
    logic [N-1:0]   overflow;
`ifdef FLAG_SCHED_OVF_CNT_EN
    logic [7:0]     ovf_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: pending/overflow as sets, slot occupancy as a countdown.
    logic [N-1:0] m_pend;
    logic [N-1:0] m_ovf;
    int           m_ptr;
    int           m_slot;   // cycles of busy remaining; 0 means free
    int           m_id;
    logic         m_flag;
    int           m_cnt;

    flag_xdomain_sched #(
        .N     (N),
        .IDW   (IDW),
        .GUARD (GUARD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .ovf_clr   (ovf_clr),
        .flag_out  (flag_out),
        .flag_id   (flag_id),
        .busy      (busy),
        .pending   (pending),
        .overflow  (overflow)
`ifdef FLAG_SCHED_OVF_CNT_EN
        ,
        .ovf_count (ovf_count)
`endif
    );

    always #5 clk = ~clk;

    // Advance the model by one clock using the inputs about to be sampled.
    task automatic model_step();
        int           g;
        int           idx;
        logic [N-1:0] clr;
        logic [N-1:0] drop;
        g   = -1;
        clr = '0;
        if (rst) begin
            m_pend = '0; m_ovf = '0; m_ptr = 0; m_slot = 0;
            m_id = 0; m_flag = 1'b0; m_cnt = 0;
        end else begin
            if (m_slot == 0 && en && m_pend != '0) begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (g < 0 && m_pend[idx]) g = idx;
                end
            end
            if (g >= 0) clr[g] = 1'b1;
            drop = req & m_pend & ~clr;
            if (ovf_clr) begin
                m_ovf = drop;
                m_cnt = (drop != '0) ? 1 : 0;
            end else begin
                m_ovf = m_ovf | drop;
                if (drop != '0 && m_cnt < 255) m_cnt = m_cnt + 1;
            end
            m_pend = (m_pend & ~clr) | req;
            if (g >= 0) begin
                m_flag = 1'b1;
                m_id   = g;
                m_ptr  = (g + 1) % N;
                m_slot = GUARD + 1;
            end else begin
                m_flag = 1'b0;
                if (m_slot > 0) m_slot = m_slot - 1;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; req = '0; ovf_clr = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({flag_out, flag_id, busy, pending, overflow} !== '0)
            $display("FAIL reset got=%b/%0d/%b/%b/%b want all zero", flag_out, flag_id, busy, pending, overflow);
        else n_pass++;
`ifdef FLAG_SCHED_OVF_CNT_EN
        n_checks++;
        if (ovf_count !== 8'd0) $display("FAIL reset.ovf_count got=%0d want=0", ovf_count);
        else n_pass++;
`endif
    endtask

    task automatic test_single();
        logic exp_b;
        do_reset();
        en = 1'b1; req = 4'b0001;
        for (int c = 1; c <= 10; c++) begin
            tick();
            req = '0;
            n_checks++;
            if (flag_out !== (c == 2)) $display("FAIL single.flag_out c=%0d got=%b want=%b", c, flag_out, (c == 2));
            else n_pass++;
            exp_b = (c >= 2 && c <= 8);
            n_checks++;
            if (busy !== exp_b) $display("FAIL single.busy c=%0d got=%b want=%b", c, busy, exp_b);
            else n_pass++;
            if (c == 1) begin
                n_checks++;
                if (pending !== 4'b0001) $display("FAIL single.pending got=%b want=0001", pending);
                else n_pass++;
            end
            if (c == 2) begin
                n_checks++;
                if (flag_id !== 2'd0) $display("FAIL single.flag_id got=%0d want=0", flag_id);
                else n_pass++;
            end
        end
    endtask

    task automatic test_all_four();
        logic exp_p;
        do_reset();
        en = 1'b1; req = 4'b1111;
        for (int c = 1; c <= 28; c++) begin
            tick();
            req = '0;
            exp_p = (c >= 2 && c <= 26 && ((c - 2) % 8) == 0);
            n_checks++;
            if (flag_out !== exp_p) $display("FAIL all4.flag_out c=%0d got=%b want=%b", c, flag_out, exp_p);
            else n_pass++;
            if (exp_p) begin
                n_checks++;
                if (flag_id !== IDW'((c - 2) / 8)) $display("FAIL all4.flag_id c=%0d got=%0d want=%0d", c, flag_id, (c - 2) / 8);
                else n_pass++;
            end
            if (c == 27) begin
                n_checks++;
                if (pending !== 4'b0000) $display("FAIL all4.pending got=%b want=0000", pending);
                else n_pass++;
            end
        end
    endtask

    task automatic test_overflow();
        int pulses;
        do_reset();
        en = 1'b0; req = 4'b0100;
        tick(); req = '0;          // cycle 1
        tick();                    // cycle 2
        tick(); req = 4'b0100;     // cycle 3
        tick(); req = '0;          // cycle 4
        n_checks++;
        if (overflow !== 4'b0100 || pending !== 4'b0100 || busy !== 1'b0)
            $display("FAIL ovf.flags got ovf=%b pend=%b busy=%b want 0100/0100/0", overflow, pending, busy);
        else n_pass++;
`ifdef FLAG_SCHED_OVF_CNT_EN
        n_checks++;
        if (ovf_count !== 8'd1) $display("FAIL ovf.count got=%0d want=1", ovf_count);
        else n_pass++;
`endif
        en = 1'b1; pulses = 0;
        for (int c = 0; c < 14; c++) begin
            tick();
            if (flag_out === 1'b1) begin
                pulses++;
                n_checks++;
                if (flag_id !== 2'd2) $display("FAIL ovf.flag_id got=%0d want=2", flag_id);
                else n_pass++;
            end
        end
        n_checks++;
        if (pulses != 1) $display("FAIL ovf.pulses got=%0d want=1", pulses);
        else n_pass++;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        n_checks++;
        if (overflow !== 4'b0000) $display("FAIL ovf.clear got=%b want=0000", overflow);
        else n_pass++;
    endtask

    task automatic test_fairness();
        int k;
        k = 0;
        do_reset();
        en = 1'b1; req = 4'b1001;
        for (int c = 1; c <= 45; c++) begin
            tick();
            if (flag_out === 1'b1) begin
                n_checks++;
                if (flag_id !== ((k % 2 == 0) ? 2'd0 : 2'd3))
                    $display("FAIL fair.flag_id pulse=%0d got=%0d want=%0d", k, flag_id, (k % 2 == 0) ? 0 : 3);
                else n_pass++;
                k++;
            end
        end
        req = '0;
        n_checks++;
        if (k != 6) $display("FAIL fair.pulses got=%0d want=6", k);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        en = 1'b1; req = 4'b0010;
        tick();                    // cycle 1: grant clears pending[1] at this edge
        req = 4'b0010;
        tick();                    // cycle 2
        req = '0;
        n_checks++;
        if (flag_out !== 1'b1 || flag_id !== 2'd1 || pending[1] !== 1'b1 || overflow[1] !== 1'b0)
            $display("FAIL simul.first got flag=%b id=%0d pend=%b ovf=%b want 1/1/xx1x/xx0x", flag_out, flag_id, pending, overflow);
        else n_pass++;
        for (int c = 3; c <= 12; c++) begin
            tick();
            n_checks++;
            if (flag_out !== (c == 10)) $display("FAIL simul.flag_out c=%0d got=%b want=%b", c, flag_out, (c == 10));
            else n_pass++;
            if (c == 10) begin
                n_checks++;
                if (flag_id !== 2'd1) $display("FAIL simul.flag_id got=%0d want=1", flag_id);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        en = 1'b1; req = 4'b1010;
        tick(); req = '0;          // cycle 1
        tick(); req = 4'b0010;     // cycle 2: pulse id 1
        tick(); req = '0;          // cycle 3
        tick();                    // cycle 4: in GUARD
        n_checks++;
        if (pending !== 4'b1010 || busy !== 1'b1)
            $display("FAIL rstmid.pre got pend=%b busy=%b want 1010/1", pending, busy);
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({flag_out, flag_id, busy, pending, overflow} !== '0)
            $display("FAIL rstmid.outputs got=%b/%0d/%b/%b/%b want all zero", flag_out, flag_id, busy, pending, overflow);
        else n_pass++;
        for (int c = 0; c < 20; c++) begin
            tick();
            n_checks++;
            if (flag_out !== 1'b0 || busy !== 1'b0) $display("FAIL rstmid.quiet c=%0d got flag=%b busy=%b want 0/0", c, flag_out, busy);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            rst     = ($urandom_range(0, 99) == 0);
            en      = ($urandom_range(0, 9) != 0);
            ovf_clr = ($urandom_range(0, 19) == 0);
            for (int b = 0; b < N; b++) req[b] = ($urandom_range(0, 5) == 0);
            tick();
            n_checks++;
            if (flag_out !== m_flag || busy !== (m_slot > 0) || flag_id !== IDW'(m_id) ||
                pending !== m_pend || overflow !== m_ovf)
                $display("FAIL rand i=%0d got flag=%b busy=%b id=%0d pend=%b ovf=%b want %b/%b/%0d/%b/%b",
                         i, flag_out, busy, flag_id, pending, overflow, m_flag, (m_slot > 0), m_id, m_pend, m_ovf);
            else n_pass++;
`ifdef FLAG_SCHED_OVF_CNT_EN
            n_checks++;
            if (ovf_count !== 8'(m_cnt)) $display("FAIL rand.ovf_count i=%0d got=%0d want=%0d", i, ovf_count, m_cnt);
            else n_pass++;
`endif
        end
        rst = 1'b0; en = 1'b0; ovf_clr = 1'b0; req = '0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; req = '0; ovf_clr = 1'b0;
        test_reset();
        test_single();
        test_all_four();
        test_overflow();
        test_fairness();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
